fft_spectrum_buffer: RTL and testbench

Display-side spectrum frame store sitting directly downstream of the FFT top-level block. It consumes the streamed per-bin modulus values (`data_sop`/`data_eop`/`data_valid`/`data_modulus`) and scales each bin to a bar height. It keeps peak-hold markers with per-frame decay and double-buffers both arrays, so the LCD driver always reads a coherent, completed frame through a random-access read port.

---
 rtl/fft_spectrum_buffer.sv | 168 ++++++++++++++++
 tb/tb_fft_spectrum_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_buffer.sv
// Double-buffered spectrum frame store: scales streamed FFT bin magnitudes to bar
// heights, keeps decaying peak markers, and exposes only completed frames for reading.
module fft_spectrum_buffer #(
  parameter int FFT_LEN = 128,
  parameter int BAR_NUM = 64,
  parameter int ADDR_W  = 6,
  parameter int SHIFT   = 4,
  parameter int BAR_MAX = 255,
  parameter int DECAY   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              data_sop,
  input  logic              data_eop,
  input  logic              data_valid,
  input  logic [15:0]       data_modulus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_bar,
  output logic [7:0]        rd_peak,
  output logic              bank_sel,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int IDX_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int BIN_W = (BAR_NUM > 1) ? $clog2(BAR_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bankSel_q, bankSel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wrEn;
  logic [IDX_W-1:0]  wrIdx;
  logic              wrHit;
  logic [BIN_W-1:0]  wrBin;
  logic [15:0]       shifted;
  logic [7:0]        height;
  logic [7:0]        dispPeak;
  logic [7:0]        decayed;
  logic [7:0]        newPeak;
  logic [BIN_W-1:0]  rdBin;
  logic              rdInRange;
  logic [7:0]        rdBar_q, rdPeak_q;
  logic [7:0]        bar_q  [2][BAR_NUM];
  logic [7:0]        peak_q [2][BAR_NUM];

  assign shifted  = data_modulus >> SHIFT;
  assign height   = (shifted > 16'(BAR_MAX)) ? 8'(BAR_MAX) : shifted[7:0];
  assign wrBin    = wrIdx[BIN_W-1:0];
  assign wrHit    = wrEn && ({1'b0, wrIdx} < (IDX_W+1)'(BAR_NUM));
  // The display bank is frozen during capture, so the decay source never races the write.
  assign dispPeak = peak_q[bankSel_q][wrBin];
  assign decayed  = (dispPeak > 8'(DECAY)) ? dispPeak - 8'(DECAY) : 8'd0;
  assign newPeak  = (height > decayed) ? height : decayed;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bankSel_d = bankSel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wrEn      = 1'b0;
    wrIdx     = idx_q;
    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (data_sop) begin
            wrIdx = '0;
            if (!data_eop) begin
              wrEn    = 1'b1;
              idx_d   = IDX_W'(1);
              state_d = CAPTURE;
            end else if (FFT_LEN == 1) begin
              wrEn      = 1'b1;
              bankSel_d = ~bankSel_q;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (data_sop) begin
            err_d = 1'b1;
            wrEn  = 1'b1;
            wrIdx = '0;
            idx_d = IDX_W'(1);
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            if (data_eop) begin
              wrEn      = 1'b1;
              bankSel_d = ~bankSel_q;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (data_eop) begin
            err_d   = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            wrEn  = 1'b1;
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bankSel_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bankSel_q <= bankSel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < BAR_NUM; k++) begin
          bar_q[b][k]  <= '0;
          peak_q[b][k] <= '0;
        end
      end
    end else if (wrHit) begin
      bar_q[~bankSel_q][wrBin]  <= height;
      peak_q[~bankSel_q][wrBin] <= newPeak;
    end
  end

  assign rdBin     = rd_addr[BIN_W-1:0];
  assign rdInRange = ({1'b0, rd_addr} < (ADDR_W+1)'(BAR_NUM));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdBar_q  <= '0;
      rdPeak_q <= '0;
    end else if (rdInRange) begin
      rdBar_q  <= bar_q[bankSel_q][rdBin];
      rdPeak_q <= peak_q[bankSel_q][rdBin];
    end else begin
      rdBar_q  <= '0;
      rdPeak_q <= '0;
    end
  end

  assign rd_bar     = rdBar_q;
  assign rd_peak    = rdPeak_q;
  assign bank_sel   = bankSel_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Directed bench for fft_spectrum_buffer: a frame-level display model feeds a read
// scoreboard queue; frame_done/frame_err pulses are counted by monitors.
module tb_fft_spectrum_buffer;

  localparam int FFT_LEN = 128;
  localparam int BAR_NUM = 64;
  localparam int ADDR_W  = 7;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              data_sop, data_eop, data_valid;
  logic [15:0]       data_modulus;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_bar, rd_peak;
  logic              bank_sel, frame_done, frame_err;

  fft_spectrum_buffer #(
    .FFT_LEN(FFT_LEN), .BAR_NUM(BAR_NUM), .ADDR_W(ADDR_W),
    .SHIFT(4), .BAR_MAX(255), .DECAY(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .data_sop(data_sop), .data_eop(data_eop), .data_valid(data_valid),
    .data_modulus(data_modulus), .rd_addr(rd_addr),
    .rd_bar(rd_bar), .rd_peak(rd_peak), .bank_sel(bank_sel),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int errCount = 0;
  int frameMod [FFT_LEN];
  logic [7:0] expBar  [BAR_NUM];
  logic [7:0] expPeak [BAR_NUM];
  logic expBank;

  typedef struct {
    int         addr;
    logic [7:0] bar;
    logic [7:0] peak;
  } rdExp_t;
  rdExp_t sb [$];

  // Pulse monitors sample mid-cycle so a one-cycle pulse is seen exactly once.
  always @(negedge sys_clk) begin
    if (frame_done === 1'b1) doneCount++;
    if (frame_err === 1'b1) errCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scaleRef(input int m);
    int h;
    h = m / 16;
    return (h > 255) ? 8'd255 : 8'(h);
  endfunction

  // Display-bank model: applied once per committed frame.
  task automatic commitModel();
    logic [7:0] h, dec;
    for (int k = 0; k < BAR_NUM; k++) begin
      h = scaleRef(frameMod[k]);
      dec = (expPeak[k] > 0) ? expPeak[k] - 8'd1 : 8'd0;
      expBar[k]  = h;
      expPeak[k] = (h > dec) ? h : dec;
    end
    expBank = ~expBank;
  endtask

  task automatic clearModel();
    for (int k = 0; k < BAR_NUM; k++) begin
      expBar[k]  = '0;
      expPeak[k] = '0;
    end
    expBank = 1'b0;
  endtask

  task automatic applyStimulus(input bit v, input bit sop, input bit eop, input int mod);
    @(negedge sys_clk);
    data_valid   = v;
    data_sop     = sop;
    data_eop     = eop;
    data_modulus = 16'(mod);
  endtask

  task automatic sendFrame(input bit gaps);
    for (int k = 0; k < FFT_LEN; k++) begin
      if (gaps)
        repeat ($urandom_range(0, 2))
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom));
      applyStimulus(1'b1, k == 0, k == FFT_LEN - 1, frameMod[k]);
    end
  endtask

  task automatic finishCommit(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    commitModel();
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    checkOutput({tag, "_bank_sel"}, 32'(bank_sel), 32'(expBank));
  endtask

  task automatic readCheck(input int addr);
    rdExp_t e;
    @(negedge sys_clk);
    data_valid = 1'b0;
    rd_addr    = ADDR_W'(addr);
    e.addr = addr;
    e.bar  = (addr < BAR_NUM) ? expBar[addr]  : 8'd0;
    e.peak = (addr < BAR_NUM) ? expPeak[addr] : 8'd0;
    sb.push_back(e);
    @(negedge sys_clk);
    e = sb.pop_front();
    checkOutput($sformatf("rd_bar[%0d]", e.addr), 32'(rd_bar), 32'(e.bar));
    checkOutput($sformatf("rd_peak[%0d]", e.addr), 32'(rd_peak), 32'(e.peak));
  endtask

  initial begin
    int doneBefore, errBefore;
    sys_rst = 1'b1;
    data_valid = 1'b0; data_sop = 1'b0; data_eop = 1'b0;
    data_modulus = '0; rd_addr = '0;
    clearModel();
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_rd_bar", 32'(rd_bar), 32'd0);
    checkOutput("reset_rd_peak", 32'(rd_peak), 32'd0);
    checkOutput("reset_bank_sel", 32'(bank_sel), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    sys_rst = 1'b0;

    // Ramp frame: bar k = k.
    doneBefore = doneCount;
    for (int k = 0; k < FFT_LEN; k++) frameMod[k] = 16 * k;
    sendFrame(1'b0);
    finishCommit("ramp");
    readCheck(10);
    readCheck(63);
    checkOutput("ramp_done_once", 32'(doneCount - doneBefore), 32'd1);

    // Saturation, out-of-range bin and out-of-range read address.
    frameMod[3]   = 16'hFFFF;
    frameMod[100] = 16'hFFFF;
    sendFrame(1'b0);
    finishCommit("sat");
    readCheck(3);
    readCheck(36);
    readCheck(64);
    readCheck(127);

    // Peak decay across successive commits.
    for (int k = 0; k < FFT_LEN; k++) frameMod[k] = 0;
    frameMod[5] = 3200;
    sendFrame(1'b0);
    finishCommit("decay0");
    readCheck(5);
    frameMod[5] = 0;
    sendFrame(1'b0);
    finishCommit("decay1");
    readCheck(5);
    sendFrame(1'b0);
    finishCommit("decay2");
    readCheck(5);
    // Back-to-back frames: sop on the cycle after the committing eop.
    doneBefore = doneCount;
    sendFrame(1'b0);
    commitModel();
    sendFrame(1'b0);
    finishCommit("b2b");
    readCheck(5);
    readCheck(3);
    checkOutput("b2b_done_count", 32'(doneCount - doneBefore), 32'd2);

    // Short frame: eop on beat 100 is discarded.
    doneBefore = doneCount;
    errBefore  = errCount;
    for (int k = 0; k <= 100; k++) applyStimulus(1'b1, k == 0, k == 100, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("short_frame_err", 32'(frame_err), 32'd1);
    checkOutput("short_frame_done", 32'(frame_done), 32'd0);
    checkOutput("short_bank_sel", 32'(bank_sel), 32'(expBank));
    readCheck(5);
    readCheck(20);
    checkOutput("short_no_done", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("short_err_once", 32'(errCount - errBefore), 32'd1);

    // sop at beat 40 restarts the frame.
    errBefore = errCount;
    for (int k = 0; k < 40; k++) applyStimulus(1'b1, k == 0, 1'b0, 16'hFFFF);
    for (int k = 0; k < FFT_LEN; k++) frameMod[k] = int'($urandom_range(0, 5000));
    sendFrame(1'b0);
    finishCommit("restart");
    checkOutput("restart_err_once", 32'(errCount - errBefore), 32'd1);
    readCheck(0);
    readCheck(39);
    readCheck(40);

    // Random valid gaps with invalid-beat sop/eop noise.
    for (int k = 0; k < FFT_LEN; k++) frameMod[k] = int'($urandom_range(0, 65535));
    sendFrame(1'b1);
    finishCommit("gaps");
    for (int a = 0; a < BAR_NUM; a++) readCheck(a);

    // Reset in the middle of capture.
    for (int k = 0; k < 60; k++) applyStimulus(1'b1, k == 0, 1'b0, int'($urandom_range(0, 4095)));
    @(negedge sys_clk);
    sys_rst = 1'b1;
    data_valid = 1'b0;
    rd_addr = ADDR_W'(5);
    repeat (2) @(negedge sys_clk);
    checkOutput("midrst_rd_bar", 32'(rd_bar), 32'd0);
    checkOutput("midrst_rd_peak", 32'(rd_peak), 32'd0);
    checkOutput("midrst_bank_sel", 32'(bank_sel), 32'd0);
    checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'd0);
    sys_rst = 1'b0;
    clearModel();
    for (int k = 0; k < FFT_LEN; k++) frameMod[k] = int'($urandom_range(0, 8191));
    sendFrame(1'b0);
    finishCommit("postrst");
    readCheck(0);
    readCheck(5);
    readCheck(63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
